cpu_sequencer: RTL and testbench

//  Multi-cycle fetch/decode/execute controller for the master CPU. Fetches a 32-bit

---
 rtl/cpu_pkg.sv | 38 +++
 rtl/cond_eval.sv | 44 ++++
 rtl/cpu_sequencer.sv | 195 +++++++++++++++++++
 tb/tb_cpu_sequencer.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// cpu_pkg
//   Shared definitions for the master CPU sequencer and its helpers:
//   sequencer state encoding, ARM-style condition codes, default opcode
//   values and the bit positions of the instruction fields.
package cpu_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_FETCH  = 3'd1,
        ST_WAIT   = 3'd2,
        ST_DECODE = 3'd3,
        ST_EXEC   = 3'd4,
        ST_MEM    = 3'd5,
        ST_WB     = 3'd6,
        ST_HALT   = 3'd7
    } state_t;

    typedef enum logic [3:0] {
        COND_EQ = 4'h0, COND_NE = 4'h1, COND_CS = 4'h2, COND_CC = 4'h3,
        COND_MI = 4'h4, COND_PL = 4'h5, COND_VS = 4'h6, COND_VC = 4'h7,
        COND_HI = 4'h8, COND_LS = 4'h9, COND_GE = 4'hA, COND_LT = 4'hB,
        COND_GT = 4'hC, COND_LE = 4'hD, COND_AL = 4'hE, COND_NV = 4'hF
    } cond_t;

    localparam logic [3:0] OP_LDR_DEF  = 4'h8;
    localparam logic [3:0] OP_STR_DEF  = 4'h9;
    localparam logic [3:0] OP_HALT_DEF = 4'hF;

    // Instruction field positions (LSB of each field)
    localparam int COND_LSB   = 28;  // [31:28]
    localparam int OPCODE_LSB = 24;  // [27:24]
    localparam int S_BIT      = 23;  // [23]
    localparam int DEST_LSB   = 19;  // [22:19]
    localparam int SRC2_LSB   = 15;  // [18:15]
    localparam int SRC1_LSB   = 11;  // [14:11]
    localparam int IV_LSB     = 6;   // [10:6]

endpackage

// File: rtl/cond_eval.sv
// cond_eval
//   Combinational evaluation of an ARM-style condition code against a
//   {N,Z,C,V} flag vector. Shared between the sequencer and the ALU.
// Ports
//   cond  in  4  condition code
//   flag  in  4  flags {N,Z,C,V}
//   pass  out 1  1 when the condition holds
module cond_eval
    import cpu_pkg::*;
(
    input  logic [3:0] cond,
    input  logic [3:0] flag,
    output logic       pass
);

    logic n, z, c, v;
    assign n = flag[3];
    assign z = flag[2];
    assign c = flag[1];
    assign v = flag[0];

    always_comb begin
        pass = 1'b0;
        case (cond)
            COND_EQ: pass = z;
            COND_NE: pass = !z;
            COND_CS: pass = c;
            COND_CC: pass = !c;
            COND_MI: pass = n;
            COND_PL: pass = !n;
            COND_VS: pass = v;
            COND_VC: pass = !v;
            COND_HI: pass = c && !z;
            COND_LS: pass = !c || z;
            COND_GE: pass = (n == v);
            COND_LT: pass = (n != v);
            COND_GT: pass = !z && (n == v);
            COND_LE: pass = z || (n != v);
            COND_AL: pass = 1'b1;
            default: pass = 1'b0;   // NV: never executes
        endcase
    end

endmodule

// File: rtl/cpu_sequencer.sv
// cpu_sequencer
//   Multi-cycle fetch/decode/execute controller for the master CPU.
//   Fetches an instruction from RAM at pc, exposes its fields, checks the
//   condition code against the flag register, then sequences execute,
//   memory access and writeback.
// Ports
//   Clk, Reset (async, active high), Start (leave IDLE, pc=0)
//   Out (RAM read data), Result (ALU result), New_Flag (ALU {N,Z,C,V})
//   Enable/RW/Address : RAM control (RW 1 = write)
//   instruction and its fields Cond, OpCode, S, destination, source_2,
//   source_1, IV
//   Flag : architectural flags; LDR/STR/reg_we : one-cycle strobes
//   pc : program counter; Halted : high in HALT
//   wb_data : ALU result captured in EXEC, presented with reg_we
module cpu_sequencer
    import cpu_pkg::*;
#(
    parameter int         RAM_LAT = 1,
    parameter logic [3:0] OP_LDR  = OP_LDR_DEF,
    parameter logic [3:0] OP_STR  = OP_STR_DEF,
    parameter logic [3:0] OP_HALT = OP_HALT_DEF
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        Start,
    input  logic [31:0] Out,
    input  logic [31:0] Result,
    input  logic [3:0]  New_Flag,
    output logic        Enable,
    output logic        RW,
    output logic [15:0] Address,
    output logic [31:0] instruction,
    output logic [3:0]  Cond,
    output logic [3:0]  OpCode,
    output logic        S,
    output logic [3:0]  destination,
    output logic [3:0]  source_2,
    output logic [3:0]  source_1,
    output logic [4:0]  IV,
    output logic [3:0]  Flag,
    output logic        LDR,
    output logic        STR,
    output logic        reg_we,
    output logic [7:0]  pc,
    output logic        Halted,
    output logic [31:0] wb_data
);

    state_t      state_q, state_d;
    logic [2:0]  cnt_q, cnt_d;
    logic [31:0] instr_q, instr_d;
    logic [7:0]  pc_q, pc_d;
    logic [3:0]  flag_q, flag_d;
    logic [31:0] wb_data_q, wb_data_d;
    logic        enable_q, enable_d;
    logic        rw_q, rw_d;
    logic [15:0] address_q, address_d;
    logic        ldr_q, ldr_d;
    logic        str_q, str_d;
    logic        reg_we_q, reg_we_d;
    logic        halted_q, halted_d;
    logic        cond_pass;
    logic [3:0]  opcode;

    assign opcode = instr_q[OPCODE_LSB +: 4];

    cond_eval u_cond_eval (
        .cond (instr_q[COND_LSB +: 4]),
        .flag (flag_q),
        .pass (cond_pass)
    );

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        instr_d   = instr_q;
        pc_d      = pc_q;
        flag_d    = flag_q;
        wb_data_d = wb_data_q;

        case (state_q)
            ST_IDLE: begin
                if (Start) begin
                    pc_d    = 8'h00;
                    state_d = ST_FETCH;
                end
            end
            ST_FETCH: begin
                cnt_d   = 3'(RAM_LAT);
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                // Counter reaches zero at the end of the last WAIT cycle,
                // so WAIT lasts exactly RAM_LAT cycles.
                cnt_d = cnt_q - 3'd1;
                if (cnt_q <= 3'd1) begin
                    instr_d = Out;
                    state_d = ST_DECODE;
                end
            end
            ST_DECODE: begin
                // HALT takes precedence over a failing condition code.
                if (opcode == OP_HALT) begin
                    state_d = ST_HALT;
                end else if (!cond_pass) begin
                    pc_d    = pc_q + 8'd1;
                    state_d = ST_FETCH;
                end else begin
                    state_d = ST_EXEC;
                end
            end
            ST_EXEC: begin
                wb_data_d = Result;
                if (instr_q[S_BIT]) flag_d = New_Flag;
                state_d = ((opcode == OP_LDR) || (opcode == OP_STR)) ? ST_MEM : ST_WB;
            end
            ST_MEM: begin
                if (opcode == OP_STR) begin
                    pc_d    = pc_q + 8'd1;
                    state_d = ST_FETCH;
                end else begin
                    state_d = ST_WB;
                end
            end
            ST_WB: begin
                pc_d    = pc_q + 8'd1;
                state_d = ST_FETCH;
            end
            ST_HALT: state_d = ST_HALT;
            default: state_d = ST_IDLE;
        endcase

        // Outputs are decoded from the next state so they register in
        // step with the state they belong to.
        enable_d  = (state_d == ST_FETCH) || (state_d == ST_WAIT) || (state_d == ST_MEM);
        address_d = ((state_d == ST_FETCH) || (state_d == ST_WAIT)) ? {8'h00, pc_d} : 16'h0000;
        ldr_d     = (state_d == ST_MEM) && (opcode == OP_LDR);
        str_d     = (state_d == ST_MEM) && (opcode == OP_STR);
        rw_d      = str_d;
        reg_we_d  = (state_d == ST_WB);
        halted_d  = (state_d == ST_HALT);
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_q   <= ST_IDLE;
            cnt_q     <= 3'd0;
            instr_q   <= 32'h0;
            pc_q      <= 8'h00;
            flag_q    <= 4'h0;
            wb_data_q <= 32'h0;
            enable_q  <= 1'b0;
            rw_q      <= 1'b0;
            address_q <= 16'h0000;
            ldr_q     <= 1'b0;
            str_q     <= 1'b0;
            reg_we_q  <= 1'b0;
            halted_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            instr_q   <= instr_d;
            pc_q      <= pc_d;
            flag_q    <= flag_d;
            wb_data_q <= wb_data_d;
            enable_q  <= enable_d;
            rw_q      <= rw_d;
            address_q <= address_d;
            ldr_q     <= ldr_d;
            str_q     <= str_d;
            reg_we_q  <= reg_we_d;
            halted_q  <= halted_d;
        end
    end

    assign Enable      = enable_q;
    assign RW          = rw_q;
    assign Address     = address_q;
    assign instruction = instr_q;
    assign Cond        = instr_q[COND_LSB +: 4];
    assign OpCode      = opcode;
    assign S           = instr_q[S_BIT];
    assign destination = instr_q[DEST_LSB +: 4];
    assign source_2    = instr_q[SRC2_LSB +: 4];
    assign source_1    = instr_q[SRC1_LSB +: 4];
    assign IV          = instr_q[IV_LSB +: 5];
    assign Flag        = flag_q;
    assign LDR         = ldr_q;
    assign STR         = str_q;
    assign reg_we      = reg_we_q;
    assign pc          = pc_q;
    assign Halted      = halted_q;
    assign wb_data     = wb_data_q;

endmodule

// File: tb/tb_cpu_sequencer.sv
// tb_cpu_sequencer
//   Directed bench: one instance with RAM_LAT=1 runs the main program
//   scenarios, a second instance with RAM_LAT=3 checks the longer wait.
module tb_cpu_sequencer;

    logic Clk = 1'b0;
    always #5 Clk = ~Clk;

    // ---------------- instance A: RAM_LAT = 1 ----------------
    logic        Reset, Start;
    logic [31:0] Out, Result;
    logic [3:0]  New_Flag;
    logic        Enable, RW, S, LDR, STR, reg_we, Halted;
    logic [15:0] Address;
    logic [31:0] instruction, wb_data;
    logic [3:0]  Cond, OpCode, destination, source_2, source_1, Flag;
    logic [4:0]  IV;
    logic [7:0]  pc;
    logic [31:0] ram [256];
    assign Out = ram[Address[7:0]];

    cpu_sequencer #(.RAM_LAT(1)) dut (
        .Clk(Clk), .Reset(Reset), .Start(Start), .Out(Out), .Result(Result),
        .New_Flag(New_Flag), .Enable(Enable), .RW(RW), .Address(Address),
        .instruction(instruction), .Cond(Cond), .OpCode(OpCode), .S(S),
        .destination(destination), .source_2(source_2), .source_1(source_1),
        .IV(IV), .Flag(Flag), .LDR(LDR), .STR(STR), .reg_we(reg_we), .pc(pc),
        .Halted(Halted), .wb_data(wb_data)
    );

    // ---------------- instance B: RAM_LAT = 3 ----------------
    logic        Reset_b, Start_b;
    logic [31:0] Out_b, Result_b;
    logic [3:0]  New_Flag_b;
    logic        Enable_b, RW_b, S_b, LDR_b, STR_b, reg_we_b, Halted_b;
    logic [15:0] Address_b;
    logic [31:0] instruction_b, wb_data_b;
    logic [3:0]  Cond_b, OpCode_b, destination_b, source_2_b, source_1_b, Flag_b;
    logic [4:0]  IV_b;
    logic [7:0]  pc_b;
    logic [31:0] ram_b [256];
    assign Out_b = ram_b[Address_b[7:0]];

    cpu_sequencer #(.RAM_LAT(3)) dut_b (
        .Clk(Clk), .Reset(Reset_b), .Start(Start_b), .Out(Out_b), .Result(Result_b),
        .New_Flag(New_Flag_b), .Enable(Enable_b), .RW(RW_b), .Address(Address_b),
        .instruction(instruction_b), .Cond(Cond_b), .OpCode(OpCode_b), .S(S_b),
        .destination(destination_b), .source_2(source_2_b), .source_1(source_1_b),
        .IV(IV_b), .Flag(Flag_b), .LDR(LDR_b), .STR(STR_b), .reg_we(reg_we_b), .pc(pc_b),
        .Halted(Halted_b), .wb_data(wb_data_b)
    );

    int checks = 0;
    int failures = 0;
    int n_we, n_ldr, n_str, n_strobe_b, n_halt;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance to the next falling edge, tallying strobes on the way.
    task automatic step(input int n = 1);
        repeat (n) begin
            @(negedge Clk);
            n_we       += int'(reg_we);
            n_ldr      += int'(LDR);
            n_str      += int'(STR);
            n_halt     += int'(Halted);
            n_strobe_b += int'(LDR_b) + int'(STR_b) + int'(reg_we_b);
            checks++;
            assert ((int'(LDR) + int'(STR) + int'(reg_we)) <= 1) else begin
                failures++;
                $error("FAIL strobe_exclusive observed=%0d%0d%0d expected=at most one", LDR, STR, reg_we);
            end
        end
    endtask

    task automatic reset_a();
        Reset = 1'b1;
        step(1);
        Reset = 1'b0;
        n_we = 0; n_ldr = 0; n_str = 0; n_halt = 0;
    endtask

    task automatic start_a();   // returns in the FETCH cycle
        Start = 1'b1;
        step(1);
        Start = 1'b0;
    endtask

    task automatic clear_ram();
        for (int i = 0; i < 256; i++) ram[i] = 32'h0;
    endtask

    initial begin
        Reset = 1'b1; Start = 1'b0; Result = 32'h1234_5678; New_Flag = 4'h0;
        Reset_b = 1'b1; Start_b = 1'b0; Result_b = 32'h0; New_Flag_b = 4'h0;
        n_we = 0; n_ldr = 0; n_str = 0; n_strobe_b = 0; n_halt = 0;
        clear_ram();
        for (int i = 0; i < 256; i++) ram_b[i] = 32'h0;

        // ---- Test 1: reset mid-WAIT, then a plain AL ALU op ----
        ram[0] = 32'hE100_0000;
        reset_a();
        chk("t1_reset_en", 32'(Enable), 0);
        chk("t1_reset_halted", 32'(Halted), 0);
        start_a();
        chk("t1_fetch_en", 32'(Enable), 1);
        step(1);
        chk("t1_wait_en", 32'(Enable), 1);
        Reset = 1'b1;
        #1;
        chk("t1_async_en", 32'(Enable), 0);
        chk("t1_async_addr", 32'(Address), 0);
        chk("t1_async_instr", instruction, 0);
        step(1);
        Reset = 1'b0;
        step(1);
        chk("t1_idle_en", 32'(Enable), 0);
        n_we = 0;
        start_a();
        chk("t1_fetch2_en", 32'(Enable), 1);
        chk("t1_fetch2_addr", 32'(Address), 0);
        chk("t1_fetch2_rw", 32'(RW), 0);
        step(2);                                   // DECODE
        chk("t1_instr", instruction, 32'hE100_0000);
        chk("t1_opcode", 32'(OpCode), 1);
        chk("t1_cond", 32'(Cond), 32'hE);
        chk("t1_decode_en", 32'(Enable), 0);
        step(2);                                   // WB
        chk("t1_wb_we", 32'(reg_we), 1);
        chk("t1_wb_data", wb_data, 32'h1234_5678);
        chk("t1_wb_pc", 32'(pc), 0);
        step(1);                                   // next FETCH
        chk("t1_pc", 32'(pc), 1);
        chk("t1_addr", 32'(Address), 1);
        chk("t1_we_count", 32'(n_we), 1);

        // ---- Test 2: S=1 sets Z; EQ executes, NE skipped ----
        clear_ram();
        ram[0] = 32'hE080_0000;
        ram[1] = 32'h0100_0000;
        ram[2] = 32'h1100_0000;
        ram[3] = 32'hEF00_0000;
        New_Flag = 4'b0100;
        reset_a();
        start_a();                                 // k=1
        step(3);                                   // k=4 EXEC
        chk("t2_flag_before", 32'(Flag), 0);
        step(1);                                   // k=5 WB
        chk("t2_flag_after", 32'(Flag), 32'h4);
        New_Flag = 4'hB;                           // must not be taken (S=0 next)
        step(5);                                   // k=10 WB of EQ op
        chk("t2_eq_we", 32'(reg_we), 1);
        chk("t2_flag_kept", 32'(Flag), 32'h4);
        step(4);                                   // k=14 FETCH pc=3
        chk("t2_skip_pc", 32'(pc), 3);
        chk("t2_skip_addr", 32'(Address), 3);
        chk("t2_we_count", 32'(n_we), 2);
        step(3);
        chk("t2_halted", 32'(Halted), 1);

        // ---- Test 3: LDR then STR ----
        clear_ram();
        ram[0] = 32'hE800_0000;
        ram[1] = 32'hE900_0000;
        ram[2] = 32'hEF00_0000;
        reset_a();
        start_a();
        step(4);                                   // k=5 MEM
        chk("t3_ldr", 32'(LDR), 1);
        chk("t3_ldr_en", 32'(Enable), 1);
        chk("t3_ldr_rw", 32'(RW), 0);
        step(1);                                   // k=6 WB
        chk("t3_ldr_off", 32'(LDR), 0);
        chk("t3_ldr_we", 32'(reg_we), 1);
        step(1);
        chk("t3_pc1", 32'(pc), 1);
        step(4);                                   // k=11 MEM (store)
        chk("t3_str", 32'(STR), 1);
        chk("t3_str_rw", 32'(RW), 1);
        chk("t3_str_en", 32'(Enable), 1);
        step(1);                                   // k=12 FETCH
        chk("t3_pc2", 32'(pc), 2);
        chk("t3_we_count", 32'(n_we), 1);
        chk("t3_ldr_count", 32'(n_ldr), 1);
        chk("t3_str_count", 32'(n_str), 1);

        // ---- Test 4: HALT ignores Start, cleared by Reset ----
        clear_ram();
        ram[0] = 32'hEF00_0000;
        reset_a();
        start_a();
        step(3);                                   // k=4 HALT
        chk("t4_halted", 32'(Halted), 1);
        chk("t4_halt_en", 32'(Enable), 0);
        n_halt = 0;
        for (int i = 0; i < 20; i++) begin
            Start = (i % 2 == 0);
            step(1);
        end
        Start = 1'b0;
        chk("t4_halt_cycles", 32'(n_halt), 20);
        chk("t4_halt_pc", 32'(pc), 0);
        chk("t4_halt_we", 32'(n_we), 0);
        Reset = 1'b1;
        #1;
        chk("t4_reset_clears", 32'(Halted), 0);
        step(1);
        Reset = 1'b0;

        // ---- Test 5: pc wraps from FF to 00 ----
        for (int i = 0; i < 255; i++) ram[i] = 32'hF100_0000;
        ram[255] = 32'hE100_0000;
        reset_a();
        start_a();
        for (int g = 0; g < 2000; g++) begin
            if (Enable && Address == 16'h00FF) break;
            step(1);
        end
        chk("t5_reach_ff", 32'(Address), 32'h00FF);
        chk("t5_never_we", 32'(n_we), 0);
        step(4);                                   // WB of AL op at FF
        chk("t5_wb_we", 32'(reg_we), 1);
        chk("t5_wb_pc", 32'(pc), 32'hFF);
        step(1);
        chk("t5_wrap_pc", 32'(pc), 0);
        chk("t5_wrap_addr", 32'(Address), 0);
        chk("t5_wrap_en", 32'(Enable), 1);

        // ---- Test 6: RAM_LAT=3, Cond=NV instruction ----
        ram_b[0] = 32'hF100_0000;
        ram_b[1] = 32'hEF00_0000;
        Reset_b = 1'b0;
        n_strobe_b = 0;
        step(1);
        Start_b = 1'b1;
        step(1);                                   // k=1 FETCH
        Start_b = 1'b0;
        chk("t6_fetch_en", 32'(Enable_b), 1);
        step(3);                                   // k=4 last WAIT
        chk("t6_wait3_en", 32'(Enable_b), 1);
        chk("t6_wait3_instr", instruction_b, 0);
        step(1);                                   // k=5 DECODE
        chk("t6_decode_en", 32'(Enable_b), 0);
        chk("t6_decode_instr", instruction_b, 32'hF100_0000);
        step(1);                                   // k=6 FETCH pc=1
        chk("t6_pc", 32'(pc_b), 1);
        chk("t6_addr", 32'(Address_b), 1);
        chk("t6_en", 32'(Enable_b), 1);
        chk("t6_no_strobes", 32'(n_strobe_b), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
